// File: rtl/modexp_engine.sv
`default_nettype none
// ============================================================================
// Module  : modexp_engine
// Purpose : base^exponent mod modulus via square-and-multiply on a bit-serial
//           Blakley multiplier, with a selectable constant-time schedule.
// Revision: 1.0
// ============================================================================
module modexp_engine #(
    parameter int W     = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ct_mode,
    input  logic [W-1:0]     base,
    input  logic [W-1:0]     exponent,
    input  logic [W-1:0]     modulus,
    output logic [W-1:0]     result,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int                 C_IDX_W   = (W > 1) ? $clog2(W) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IX = C_IDX_W'(W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        REDUCE = 3'd2,
        SQR    = 3'd3,
        MUL    = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_exp;
    logic [W-1:0]       r_mod;
    logic [W-1:0]       r_acc;
    logic [W-1:0]       r_bm;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W+1:0]       r_t;
    logic [C_IDX_W-1:0] r_i;
    logic [C_IDX_W-1:0] r_j;
    logic               r_ct;
    logic               r_err;
    logic [CNT_W-1:0]   r_cycles;

    logic [W+1:0] w_mod_x;
    logic [W+1:0] w_sum;
    logic [W+1:0] w_sub1;
    logic [W+1:0] w_sub2;
    logic [W-1:0] w_prod;
    logic [W-1:0] w_next_acc;
    logic         w_mm_last;
    logic         w_ebit;

    // One Blakley step: t < m and b < m keep 2t+b below 3m, so two
    // conditional subtractions always restore t < m.
    assign w_mod_x    = {2'b00, r_mod};
    assign w_sum      = (r_t << 1) + (r_a[W-1] ? {2'b00, r_b} : {(W+2){1'b0}});
    assign w_sub1     = (w_sum  >= w_mod_x) ? (w_sum  - w_mod_x) : w_sum;
    assign w_sub2     = (w_sub1 >= w_mod_x) ? (w_sub1 - w_mod_x) : w_sub1;
    assign w_prod     = w_sub2[W-1:0];
    assign w_mm_last  = (r_j == '0);
    assign w_ebit     = r_exp[r_i];
    assign w_next_acc = (r_state == MUL && !w_ebit) ? r_acc : w_prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_exp       <= '0;
            r_mod       <= '0;
            r_acc       <= '0;
            r_bm        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_t         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_ct        <= 1'b0;
            r_err       <= 1'b0;
            r_cycles    <= '0;
            result      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
        end else begin
            done <= 1'b0;
            if (r_state != IDLE) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ct     <= ct_mode;
                        r_exp    <= exponent;
                        r_mod    <= modulus;
                        r_a      <= base;
                        r_b      <= W'(1);
                        r_cycles <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_t <= '0;
                    r_j <= C_LAST_IX;
                    r_i <= C_LAST_IX;
                    if (r_mod < W'(2)) begin
                        r_err   <= 1'b1;
                        r_acc   <= '0;
                        r_state <= FINISH;
                    end else begin
                        r_err   <= 1'b0;
                        r_acc   <= W'(1);
                        r_state <= REDUCE;
                    end
                end
                REDUCE, SQR, MUL: begin
                    r_t <= w_sub2;
                    r_a <= r_a << 1;
                    r_j <= r_j - C_IDX_W'(1);
                    if (w_mm_last) begin
                        r_t <= '0;
                        r_j <= C_LAST_IX;
                        if (r_state == REDUCE) begin
                            r_bm    <= w_prod;
                            r_a     <= r_acc;
                            r_b     <= r_acc;
                            r_state <= SQR;
                        end else if (r_state == SQR && (r_ct || w_ebit)) begin
                            r_acc   <= w_prod;
                            r_a     <= w_prod;
                            r_b     <= r_bm;
                            r_state <= MUL;
                        end else begin
                            // Bit i finished: a dummy MUL (ct_mode, bit 0) keeps acc.
                            r_acc <= w_next_acc;
                            r_a   <= w_next_acc;
                            r_b   <= w_next_acc;
                            if (r_i == '0) begin
                                r_state <= FINISH;
                            end else begin
                                r_i     <= r_i - C_IDX_W'(1);
                                r_state <= SQR;
                            end
                        end
                    end
                end
                FINISH: begin
                    result      <= r_err ? '0 : r_acc;
                    err         <= r_err;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    cycle_count <= r_cycles + CNT_W'(1);
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_modexp_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_modexp_engine
// Purpose : directed self-checking bench for modexp_engine (W=16).
// Revision: 1.0
// ============================================================================
module tb_modexp_engine;

    localparam int W     = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             ct_mode;
    logic [W-1:0]     base;
    logic [W-1:0]     exponent;
    logic [W-1:0]     modulus;
    logic [W-1:0]     result;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] cycle_count;

    int n_vec  = 0;
    int n_miss = 0;

    modexp_engine #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ct_mode     (ct_mode),
        .base        (base),
        .exponent    (exponent),
        .modulus     (modulus),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Presents one request and waits (bounded) for done; lat counts cycles from accept.
    task automatic do_op(input logic ct, input logic [W-1:0] b, input logic [W-1:0] e,
                         input logic [W-1:0] m, output bit to, output int lat);
        @(negedge clk);
        ct_mode = ct; base = b; exponent = e; modulus = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        to = 1'b1;
        lat = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ct_mode = 1'b0; base = '0; exponent = '0; modulus = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({result, busy, done, err, cycle_count} !== '0) begin
            n_miss++;
            $display("FAIL reset_outputs: result=%0d busy=%b done=%b err=%b count=%0d, required all 0",
                     result, busy, done, err, cycle_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_op(input string name, input logic ct, input logic [W-1:0] b,
                            input logic [W-1:0] e, input logic [W-1:0] m,
                            input logic [W-1:0] exp_res, input int exp_cnt, input logic exp_err);
        bit to;
        int lat;
        do_op(ct, b, e, m, to, lat);
        n_vec++;
        if (to) begin
            n_miss++;
            $display("FAIL %s_timeout: done never seen, required within 3000 cycles", name);
        end else begin
            if (result !== exp_res) begin
                n_miss++;
                $display("FAIL %s_result: got %0d, required %0d", name, result, exp_res);
            end
            n_vec++;
            if (cycle_count !== CNT_W'(exp_cnt) || lat != exp_cnt) begin
                n_miss++;
                $display("FAIL %s_cycles: count=%0d latency=%0d, required %0d", name, cycle_count, lat, exp_cnt);
            end
            n_vec++;
            if (err !== exp_err) begin
                n_miss++;
                $display("FAIL %s_err: got %b, required %b", name, err, exp_err);
            end
            @(negedge clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_miss++;
                $display("FAIL %s_done_pulse: done=%b busy=%b one cycle later, required 0 0", name, done, busy);
            end
        end
    endtask

    task automatic test_normal();
        check_op("norm_enc", 1'b0, 16'd65,   16'd17,   16'd3233, 16'd2790, 306, 1'b0);
        check_op("norm_dec", 1'b0, 16'd2790, 16'd2753, 16'd3233, 16'd65,   354, 1'b0);
    endtask

    task automatic test_ct_mode();
        check_op("ct_enc", 1'b1, 16'd65,   16'd17,   16'd3233, 16'd2790, 530, 1'b0);
        check_op("ct_dec", 1'b1, 16'd2790, 16'd2753, 16'd3233, 16'd65,   530, 1'b0);
    endtask

    task automatic test_edges();
        check_op("base_gt_mod", 1'b0, 16'd4000, 16'd1, 16'd3233, 16'd767, 290, 1'b0);
        check_op("exp_zero",    1'b0, 16'd5,    16'd0, 16'd3233, 16'd1,   274, 1'b0);
        check_op("mod_one",     1'b0, 16'd9,    16'd3, 16'd1,    16'd0,   2,   1'b1);
        check_op("err_clear",   1'b1, 16'd3,    16'd5, 16'd7,    16'd5,   530, 1'b0);
    endtask

    task automatic test_busy_ignore();
        bit seen;
        @(negedge clk);
        ct_mode = 1'b0; base = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        ct_mode = 1'b1; base = 16'd5; exponent = 16'd0; modulus = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        n_vec++;
        if (!seen || result !== 16'd2790 || cycle_count !== CNT_W'(306)) begin
            n_miss++;
            $display("FAIL busy_ignore: done=%b result=%0d count=%0d, required 1 2790 306",
                     seen, result, cycle_count);
        end
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        n_vec++;
        if (seen || result !== 16'd2790) begin
            n_miss++;
            $display("FAIL busy_ignore_after: extra activity=%b result=%0d, required 0 2790", seen, result);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ct_mode = 1'b0; base = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_mid_busy_before: got %b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({result, busy, done, err, cycle_count} !== '0) begin
            n_miss++;
            $display("FAIL reset_mid_outputs: result=%0d busy=%b done=%b err=%b count=%0d, required all 0",
                     result, busy, done, err, cycle_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_op("after_reset", 1'b0, 16'd65, 16'd17, 16'd3233, 16'd2790, 306, 1'b0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_ct_mode();
        test_edges();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modexp_engine.md
Name: modexp_engine

Overview:
- Parametrised modular-exponentiation core computing result = base^exponent mod modulus with a start/busy/done handshake.
- Drop-in successor to the fixed 16-bit exponentiation inside the RSA encrypt/decrypt path.
- Adds a runtime constant-time mode, so the same core can demonstrate the square-and-multiply timing leak or suppress it.
- Exports a per-operation cycle count so timing-attack benches can measure latency directly.

Parameters:
- W, 16, operand width in bits for base, exponent, modulus and result.
- CNT_W, 32, width of the cycle_count output.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; accepted only when busy=0.
- ct_mode  in  1  1 = constant-time schedule, 0 = data-dependent schedule; sampled at accept.
- base  in  W  message or ciphertext; sampled at accept.
- exponent  in  W  e or d; sampled at accept.
- modulus  in  W  n; sampled at accept.
- result  out  W  base^exponent mod modulus; held until the next accept.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when result becomes valid.
- err  out  1  set with done when modulus<2; cleared at the next accept.
- cycle_count  out  CNT_W  number of cycles busy was high for the last operation; held until the next accept.

Behaviour:
- Reset (asynchronous, any state): result=0, busy=0, done=0, err=0, cycle_count=0, FSM=IDLE, all internal registers 0.
- Accept: at a rising edge with start=1 and busy=0, latch all inputs; busy=1 from the next cycle. start while busy=1 is ignored.
- FSM states: IDLE, LOAD, REDUCE, SQR, MUL, FINISH.
- IDLE -> LOAD on accept.
- LOAD lasts 1 cycle.
  - If modulus<2: go to FINISH with result=0, err=1.
  - Otherwise: acc=1, bit index i=W-1, go to REDUCE.
- Modular multiply: bit-serial interleaved (Blakley) on a (W+2)-bit accumulator.
  - Takes exactly W cycles, one multiplier bit per cycle, MSB first.
  - Per cycle: t = 2*t + (a_bit ? b : 0), then subtract modulus up to twice so that t < modulus.
  - No divider is used.
- REDUCE (W cycles): bm = modmul(base, 1), i.e. base mod modulus. Inputs with base >= modulus are legal.
- SQR (W cycles): acc = modmul(acc, acc).
- MUL (W cycles): prod = modmul(acc, bm).
  - Exponent bit i = 1: acc = prod.
  - Exponent bit i = 0 (ct_mode only): prod is computed and discarded.
- Transition rules after SQR:
  - ct_mode=1: always go to MUL.
  - ct_mode=0: go to MUL only if exponent[i]=1; otherwise move to the next bit.
- Bit advance: after the last operation for bit i, decrement i. After i=0, go to FINISH.
- No leading-zero skipping in either mode; all W exponent bits are scanned.
- FINISH lasts 1 cycle.
  - result=acc (or 0 on err), done=1, busy=0, cycle_count=final count, FSM=IDLE.
  - A start arriving in the FINISH cycle is not accepted; it must be presented again in IDLE.
- Counter: cleared at accept, incremented every cycle busy=1.
- Busy-cycle totals:
  - Normal mode: 1 + W + W*(W + popcount(exponent)) + 1.
  - ct_mode: 1 + W + 2*W*W + 1.
  - modulus<2: 2 (LOAD + FINISH).
- exponent=0: result = 1 (when modulus >= 2).
- The ct_mode cycle count is independent of the exponent, base and modulus values.
- Reset asserted mid-operation: aborts immediately; no done pulse; outputs return to reset values.

Test Plan:
- W=16, ct_mode=0, base=65, exponent=17, modulus=3233 -> done with result=2790, err=0, cycle_count=1+16+16*18+1=306.
- W=16, ct_mode=0, base=2790, exponent=2753 (0x0AC1, popcount 5), modulus=3233 -> result=65, cycle_count=1+16+16*21+1=354.
- Same two operations with ct_mode=1 -> results 2790 and 65; both cycle_count=1+16+512+1=530, proving count is independent of exponent.
- Edge operands:
  - base=4000 (>modulus), exponent=1, modulus=3233 -> result=767.
  - base=5, exponent=0, modulus=3233 -> result=1.
  - modulus=1 -> result=0, err=1, done 2 cycles after accept, cycle_count=2.
- Handshake:
  - Pulse start again while busy -> ignored; result and cycle_count unchanged from the first operation.
  - Assert rst_n=0 mid-SQR -> busy, done, result, cycle_count all 0 immediately; a new start afterwards completes correctly.
